// File: rtl/latch_bank_writer.sv
// Purpose: write sequencer in front of DEPTH transparent latch arrays (SETUP -> PULSE -> HOLD per write).
// Latency: accept at edge T -> enable high T+2..T+1+PULSE_CYCLES, wr_done at T+2+PULSE_CYCLES.
// Backpressure: in_ready only in IDLE; out-of-range writes are dropped in one cycle with wr_err.
module latch_bank_writer #(
  parameter int DWIDTH       = 3,
  parameter int DEPTH        = 4,
  parameter int AWIDTH       = 2,
  parameter int PULSE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_data,
  output logic [DWIDTH-1:0] lat_data,
  output logic [DEPTH-1:0]  lat_ena,
  output logic              wr_done,
  output logic              wr_err
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [DEPTH-1:0]    ena_q, ena_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DEPTH-1:0]    onehot;
  logic                addr_ok;

  // Ready is purely a function of state and reset, never of the request itself.
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign lat_data = data_q;
  assign lat_ena  = ena_q;
  assign wr_done  = done_q;
  assign wr_err   = err_q;

  // Decode the captured address to a one-hot enable and range-check the incoming one.
  always_comb begin
    onehot  = '0;
    addr_ok = (int'(in_addr) < DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = (int'(addr_q) == i);
    end
  end

  // Next-state logic; enables and data are computed here but only ever leave through flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ena_d   = ena_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (addr_ok) begin
            addr_d  = in_addr;
            data_d  = in_data;
            state_d = S_SETUP;
          end else begin
            // Dropped write: data bus untouched, stay ready for the next request.
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        ena_d   = onehot;
        cnt_d   = CW'(PULSE_CYCLES - 1);
      end
      S_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_HOLD;
          ena_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ena_d   = '0;
      end
    endcase
  end

  // State register; reset aborts any write in progress and clears the data bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ena_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: two configurations (DEPTH=3/PULSE=1 and DEPTH=4/PULSE=3),
// directed scenarios with literal expectations followed by randomized traffic,
// all checked against a timeline model of each write.
module tb_latch_bank_writer;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s      [NDUT];
  logic       in_valid_s [NDUT];
  logic [1:0] in_addr_s  [NDUT];
  logic [2:0] in_data_s  [NDUT];
  logic       in_ready_s [NDUT];
  logic [2:0] lat_data_s [NDUT];
  logic [3:0] lat_ena_s  [NDUT];
  logic       wr_done_s  [NDUT];
  logic       wr_err_s   [NDUT];
  logic [2:0] ena0;
  logic [3:0] ena1;

  latch_bank_writer #(.DWIDTH(3), .DEPTH(3), .AWIDTH(2), .PULSE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_addr(in_addr_s[0]), .in_data(in_data_s[0]), .lat_data(lat_data_s[0]),
    .lat_ena(ena0), .wr_done(wr_done_s[0]), .wr_err(wr_err_s[0])
  );

  latch_bank_writer #(.DWIDTH(3), .DEPTH(4), .AWIDTH(2), .PULSE_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_addr(in_addr_s[1]), .in_data(in_data_s[1]), .lat_data(lat_data_s[1]),
    .lat_ena(ena1), .wr_done(wr_done_s[1]), .wr_err(wr_err_s[1])
  );

  assign lat_ena_s[0] = {1'b0, ena0};
  assign lat_ena_s[1] = ena1;

  function automatic int dep_of(input int g);
    return (g == 0) ? 3 : 4;
  endfunction

  function automatic int pc_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Literal expectations captured by the stimulus process, compared by the checker process.
  typedef struct {
    string       name;
    int          dut;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q[$];

  task automatic lit(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    lit_t x;
    x.name = n;
    x.dut  = g;
    x.act  = a;
    x.exp  = e;
    lit_q.push_back(x);
  endtask

  task automatic chk(input string n, input int g, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", n, g, cyc, a, e);
    end
  endtask

  // Timeline model: a write accepted in cycle t0 is fully described by k = cycle - t0.
  logic        live  [NDUT];
  logic        act   [NDUT];
  int          t0    [NDUT];
  logic [1:0]  a0    [NDUT];
  logic [2:0]  edata [NDUT];
  int          errc  [NDUT];
  int          m_k, m_pc;
  logic        m_busy, m_rdy;
  logic [3:0]  m_ena;
  lit_t        m_lit;

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      live[g] = 1'b0; act[g] = 1'b0; t0[g] = 0; a0[g] = '0; edata[g] = '0; errc[g] = -1;
    end
  end

  always @(negedge clk) begin
    while (lit_q.size() > 0) begin
      m_lit = lit_q.pop_front();
      chk(m_lit.name, m_lit.dut, m_lit.act, m_lit.exp);
    end
    for (int g = 0; g < NDUT; g++) begin
      m_pc   = pc_of(g);
      m_k    = cyc - t0[g];
      m_busy = act[g] && (m_k < m_pc + 3);
      m_rdy  = !rst_s[g] && !m_busy;
      m_ena  = (act[g] && m_k >= 2 && m_k <= m_pc + 1) ? (4'd1 << a0[g]) : 4'd0;
      if (live[g]) begin
        chk("in_ready", g, 32'(in_ready_s[g]), 32'(m_rdy));
        chk("lat_ena",  g, 32'(lat_ena_s[g]),  32'(m_ena));
        chk("lat_data", g, 32'(lat_data_s[g]), 32'(edata[g]));
        chk("wr_done",  g, 32'(wr_done_s[g]),  32'(act[g] && m_k == m_pc + 2));
        chk("wr_err",   g, 32'(wr_err_s[g]),   32'(errc[g] == cyc));
      end
      if (rst_s[g]) begin
        live[g]  = 1'b1;
        act[g]   = 1'b0;
        edata[g] = '0;
        errc[g]  = -1;
      end else if (m_rdy && in_valid_s[g]) begin
        if (int'(in_addr_s[g]) < dep_of(g)) begin
          act[g]   = 1'b1;
          t0[g]    = cyc;
          a0[g]    = in_addr_s[g];
          edata[g] = in_data_s[g];
        end else begin
          errc[g] = cyc + 1;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      rst_s[g] = 1'b1; in_valid_s[g] = 1'b1; in_addr_s[g] = 2'd2; in_data_s[g] = 3'd5;
    end
    // Reset held two cycles with a pending request: nothing accepted.
    step();
    step();
    for (int g = 0; g < NDUT; g++) begin
      lit("rst_ready", g, 32'(in_ready_s[g]), 32'd0);
      lit("rst_ena",   g, 32'(lat_ena_s[g]),  32'd0);
      lit("rst_data",  g, 32'(lat_data_s[g]), 32'd0);
      rst_s[g] = 1'b0; in_valid_s[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < NDUT; g++) lit("rel_ready", g, 32'(in_ready_s[g]), 32'd1);

    // Single write, dut0 (PULSE=1): addr 2, data 101.
    in_valid_s[0] = 1'b1; in_addr_s[0] = 2'd2; in_data_s[0] = 3'b101;
    step(); in_valid_s[0] = 1'b0;
    lit("sw_data_t1", 0, 32'(lat_data_s[0]), 32'h5);
    lit("sw_ena_t1",  0, 32'(lat_ena_s[0]),  32'h0);
    lit("sw_rdy_t1",  0, 32'(in_ready_s[0]), 32'h0);
    step(); lit("sw_ena_t2",  0, 32'(lat_ena_s[0]), 32'h4);
    step(); lit("sw_ena_t3",  0, 32'(lat_ena_s[0]), 32'h0);
    lit("sw_done_t3", 0, 32'(wr_done_s[0]), 32'h1);
    step(); lit("sw_rdy_t4",  0, 32'(in_ready_s[0]), 32'h1);
    lit("sw_done_t4", 0, 32'(wr_done_s[0]), 32'h0);

    // Back-to-back on dut0 with in_valid held: (1,011) then (2,110).
    in_valid_s[0] = 1'b1; in_addr_s[0] = 2'd1; in_data_s[0] = 3'b011;
    step(); in_addr_s[0] = 2'd2; in_data_s[0] = 3'b110;
    lit("bb_data_t1", 0, 32'(lat_data_s[0]), 32'h3);
    step(); lit("bb_ena_t2",  0, 32'(lat_ena_s[0]), 32'h2);
    step(); lit("bb_done_t3", 0, 32'(wr_done_s[0]), 32'h1);
    step(); lit("bb_rdy_t4",  0, 32'(in_ready_s[0]), 32'h1);
    lit("bb_data_t4", 0, 32'(lat_data_s[0]), 32'h3);
    step(); in_valid_s[0] = 1'b0;
    lit("bb_data_t5", 0, 32'(lat_data_s[0]), 32'h6);
    lit("bb_ena_t5",  0, 32'(lat_ena_s[0]),  32'h0);
    step(); lit("bb_ena_t6",  0, 32'(lat_ena_s[0]), 32'h4);
    step(); step();

    // Out-of-range on dut0 (DEPTH=3): addr 3 dropped, next write accepted immediately.
    in_valid_s[0] = 1'b1; in_addr_s[0] = 2'd3; in_data_s[0] = 3'b111;
    step();
    lit("oor_err",   0, 32'(wr_err_s[0]),   32'h1);
    lit("oor_rdy",   0, 32'(in_ready_s[0]), 32'h1);
    lit("oor_data",  0, 32'(lat_data_s[0]), 32'h6);
    lit("oor_ena",   0, 32'(lat_ena_s[0]),  32'h0);
    in_addr_s[0] = 2'd0; in_data_s[0] = 3'b001;
    step(); in_valid_s[0] = 1'b0;
    lit("oor_err_t2",  0, 32'(wr_err_s[0]),   32'h0);
    lit("oor_data_t2", 0, 32'(lat_data_s[0]), 32'h1);
    lit("oor_rdy_t2",  0, 32'(in_ready_s[0]), 32'h0);
    step(); step(); step();

    // Long pulse on dut1 (PULSE=3): addr 0, data 6.
    in_valid_s[1] = 1'b1; in_addr_s[1] = 2'd0; in_data_s[1] = 3'd6;
    step(); in_valid_s[1] = 1'b0;
    lit("lp_data_t1", 1, 32'(lat_data_s[1]), 32'h6);
    for (int i = 2; i <= 6; i++) begin
      step();
      lit("lp_ena",  1, 32'(lat_ena_s[1]), (i <= 4) ? 32'h1 : 32'h0);
      lit("lp_done", 1, 32'(wr_done_s[1]), (i == 5) ? 32'h1 : 32'h0);
    end
    lit("lp_rdy_t6", 1, 32'(in_ready_s[1]), 32'h1);

    // Reset during the first PULSE cycle on dut1.
    in_valid_s[1] = 1'b1; in_addr_s[1] = 2'd3; in_data_s[1] = 3'd2;
    step(); in_valid_s[1] = 1'b0;
    step(); lit("rp_ena_pulse", 1, 32'(lat_ena_s[1]), 32'h8);
    rst_s[1] = 1'b1;
    step();
    lit("rp_ena",  1, 32'(lat_ena_s[1]),  32'h0);
    lit("rp_done", 1, 32'(wr_done_s[1]),  32'h0);
    lit("rp_data", 1, 32'(lat_data_s[1]), 32'h0);
    rst_s[1] = 1'b0;
    #1;
    lit("rp_rdy", 1, 32'(in_ready_s[1]), 32'h1);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic on both configurations.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int g = 0; g < NDUT; g++) begin
        rst_s[g]      = ($urandom_range(0, 63) == 0);
        in_valid_s[g] = ($urandom_range(0, 2) != 0);
        in_addr_s[g]  = 2'($urandom_range(0, 3));
        in_data_s[g]  = 3'($urandom_range(0, 7));
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      rst_s[g] = 1'b0; in_valid_s[g] = 1'b0;
    end
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
